// File: rtl/writeback_arb_pkg.sv
// rtl/writeback_arb_pkg.sv - shared CPU register-file widths and writeback arbitration types
package writeback_arb_pkg;

  localparam int CPU_XLEN  = 32;
  localparam int CPU_RSELW = 4;

  typedef enum logic [1:0] {
    WIN_NONE = 2'd0,
    WIN_ALU  = 2'd1,
    WIN_LDQ  = 2'd2
  } wb_win_e;

endpackage

// File: rtl/writeback_arb_if.sv
// rtl/writeback_arb_if.sv - writeback port bundle: ALU/load result offers, register file write, hazard query
interface writeback_arb_if
  import writeback_arb_pkg::*;
#(
  parameter int WIDTH     = CPU_XLEN,
  parameter int RSELWIDTH = CPU_RSELW,
  parameter int DEPTH     = 4,
  localparam int CW       = $clog2(DEPTH) + 1
) ();

  logic                 alu_valid;
  logic [RSELWIDTH-1:0] alu_sel;
  logic [WIDTH-1:0]     alu_data;
  logic                 alu_ready;

  logic                 ld_valid;
  logic [RSELWIDTH-1:0] ld_sel;
  logic [WIDTH-1:0]     ld_data;
  logic                 ld_ready;

  logic                 rf_we;
  logic [RSELWIDTH-1:0] rf_wsel;
  logic [WIDTH-1:0]     rf_wdata;

  logic [RSELWIDTH-1:0] q_sel;
  logic                 q_busy;
  logic [CW-1:0]        count;

  modport master (
    output alu_valid, alu_sel, alu_data, ld_valid, ld_sel, ld_data, q_sel,
    input  alu_ready, ld_ready, rf_we, rf_wsel, rf_wdata, q_busy, count
  );

  modport slave (
    input  alu_valid, alu_sel, alu_data, ld_valid, ld_sel, ld_data, q_sel,
    output alu_ready, ld_ready, rf_we, rf_wsel, rf_wdata, q_busy, count
  );

endinterface

// File: rtl/writeback_arb_fifo.sv
// rtl/writeback_arb_fifo.sv - load-result FIFO (wb_fifo) exposing per-entry valid/sel for hazard compare
module wb_fifo
  import writeback_arb_pkg::*;
#(
  parameter int WIDTH     = CPU_XLEN,
  parameter int RSELWIDTH = CPU_RSELW,
  parameter int DEPTH     = 4,
  localparam int PW       = $clog2(DEPTH),
  localparam int CW       = PW + 1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            push,
  input  logic [RSELWIDTH-1:0]            push_sel,
  input  logic [WIDTH-1:0]                push_data,
  input  logic                            pop,
  output logic [RSELWIDTH-1:0]            head_sel,
  output logic [WIDTH-1:0]                head_data,
  output logic [CW-1:0]                   count,
  output logic [DEPTH-1:0]                ent_valid,
  output logic [DEPTH-1:0][RSELWIDTH-1:0] ent_sel
);

  logic [PW-1:0]                   wr_ptr;
  logic [PW-1:0]                   rd_ptr;
  logic [DEPTH-1:0][RSELWIDTH-1:0] sel_mem;
  logic [DEPTH-1:0][WIDTH-1:0]     data_mem;
  logic                            do_push;
  logic                            do_pop;

  assign do_push = push && (count != CW'(DEPTH));
  assign do_pop  = pop && (count != '0);

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      ent_valid <= '0;
    end else begin
      if (do_pop) begin
        rd_ptr            <= rd_ptr + PW'(1);
        ent_valid[rd_ptr] <= 1'b0;
      end
      if (do_push) begin
        wr_ptr            <= wr_ptr + PW'(1);
        ent_valid[wr_ptr] <= 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      sel_mem[wr_ptr]  <= push_sel;
      data_mem[wr_ptr] <= push_data;
    end
  end

  assign head_sel  = sel_mem[rd_ptr];
  assign head_data = data_mem[rd_ptr];
  assign ent_sel   = sel_mem;

endmodule

// File: rtl/writeback_arb.sv
// rtl/writeback_arb.sv - register file write-port arbiter between ALU results and queued load results
module writeback_arb
  import writeback_arb_pkg::*;
#(
  parameter int WIDTH     = CPU_XLEN,
  parameter int RSELWIDTH = CPU_RSELW,
  parameter int DEPTH     = 4,
  parameter int STARVE    = 4,
  localparam int CW       = $clog2(DEPTH) + 1,
  localparam int SW       = $clog2(STARVE + 1)
) (
  input  logic            clk,
  input  logic            rst,
  writeback_arb_if.slave  bus
);

  logic [RSELWIDTH-1:0]            head_sel;
  logic [WIDTH-1:0]                head_data;
  logic [CW-1:0]                   count;
  logic [DEPTH-1:0]                ent_valid;
  logic [DEPTH-1:0][RSELWIDTH-1:0] ent_sel;

  logic          alu_hazard;
  logic          q_hit;
  logic          starve_ovr;
  logic          alu_ready;
  logic          ld_ready;
  logic [SW-1:0] starve_cnt;
  wb_win_e       win;

  logic                 rf_we;
  logic [RSELWIDTH-1:0] rf_wsel;
  logic [WIDTH-1:0]     rf_wdata;

  wb_fifo #(
    .WIDTH     (WIDTH),
    .RSELWIDTH (RSELWIDTH),
    .DEPTH     (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (bus.ld_valid && ld_ready),
    .push_sel  (bus.ld_sel),
    .push_data (bus.ld_data),
    .pop       (win == WIN_LDQ),
    .head_sel  (head_sel),
    .head_data (head_data),
    .count     (count),
    .ent_valid (ent_valid),
    .ent_sel   (ent_sel)
  );

  // Only queued entries count; the registered write already in flight lands before any reader.
  always_comb begin
    alu_hazard = 1'b0;
    q_hit      = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ent_valid[i] && (ent_sel[i] == bus.alu_sel)) alu_hazard = 1'b1;
      if (ent_valid[i] && (ent_sel[i] == bus.q_sel))   q_hit      = 1'b1;
    end
  end

  assign starve_ovr = (starve_cnt == SW'(STARVE));
  assign alu_ready  = !rst && !alu_hazard && !starve_ovr;
  assign ld_ready   = !rst && (count < CW'(DEPTH));

  always_comb begin
    win = WIN_NONE;
    if (bus.alu_valid && alu_ready) win = WIN_ALU;
    else if (count != '0)           win = WIN_LDQ;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if ((count == '0) || (win == WIN_LDQ)) begin
      starve_cnt <= '0;
    end else if (win == WIN_ALU) begin
      starve_cnt <= starve_cnt + SW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rf_we    <= 1'b0;
      rf_wsel  <= '0;
      rf_wdata <= '0;
    end else begin
      case (win)
        WIN_ALU: begin
          rf_we    <= 1'b1;
          rf_wsel  <= bus.alu_sel;
          rf_wdata <= bus.alu_data;
        end
        WIN_LDQ: begin
          rf_we    <= 1'b1;
          rf_wsel  <= head_sel;
          rf_wdata <= head_data;
        end
        default: rf_we <= 1'b0;
      endcase
    end
  end

  assign bus.alu_ready = alu_ready;
  assign bus.ld_ready  = ld_ready;
  assign bus.rf_we     = rf_we;
  assign bus.rf_wsel   = rf_wsel;
  assign bus.rf_wdata  = rf_wdata;
  assign bus.q_busy    = !rst && q_hit;
  assign bus.count     = count;

endmodule
